// File: rtl/flit_pipe_pkg.sv
// Shared types and sizing helpers for the flit skid pipeline.
package flit_pipe_pkg;
  localparam int MAX_DEPTH = 8;

  // Bit 1 is the main-valid flag, bit 0 the skid-valid flag.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } stage_state_e;

  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction
endpackage

// File: rtl/flit_skid_stage.sv
// One main+skid register stage; upstream ready comes straight from the skid-valid flop.
module flit_skid_stage
  import flit_pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_ready_o,
  output logic             dn_valid_o,
  output logic [WIDTH-1:0] dn_data_o,
  input  logic             dn_ready_i
);
  stage_state_e     state_q, state_d;
  logic [WIDTH-1:0] m_d_q, m_d_d, s_d_q, s_d_d;
  logic             up, dn;

  assign up_ready_o = ~state_q[0];
  assign dn_valid_o = state_q[1];
  assign dn_data_o  = m_d_q;
  assign up         = up_valid_i & ~state_q[0];
  assign dn         = state_q[1] & dn_ready_i;

  always_comb begin
    state_d = state_q;
    m_d_d   = m_d_q;
    s_d_d   = s_d_q;
    unique case (state_q)
      EMPTY: if (up) begin
        state_d = ONE;
        m_d_d   = up_data_i;
      end
      ONE: begin
        if (up && !dn) begin
          state_d = TWO;
          s_d_d   = up_data_i;
        end else if (dn && !up) begin
          state_d = EMPTY;
        end else if (up && dn) begin
          m_d_d = up_data_i;
        end
      end
      TWO: if (dn) begin
        state_d = ONE;
        m_d_d   = s_d_q;
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops every valid but keeps data registers quiet.
    if (flush_i) begin
      state_d = EMPTY;
      m_d_d   = m_d_q;
      s_d_d   = s_d_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      m_d_q   <= RESET_VAL;
      s_d_q   <= RESET_VAL;
    end else begin
      state_q <= state_d;
      m_d_q   <= m_d_d;
      s_d_q   <= s_d_d;
    end
  end

  a_no_skid_only: assert property (@(posedge clk) disable iff (rst)
    state_q inside {EMPTY, ONE, TWO});
endmodule

// File: rtl/flit_pipe_skid.sv
// Elastic DEPTH-stage flit pipeline with occupancy count.
// Optional synchronous flush port enabled by FLIT_PIPE_FLUSH_EN.
module flit_pipe_skid
  import flit_pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
`ifdef FLIT_PIPE_FLUSH_EN
  input  logic                         flush,
`endif
  output logic [occ_width(DEPTH)-1:0]  occ
);
  localparam int OW = occ_width(DEPTH);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
    $error("flit_pipe_skid: DEPTH must be 1..%0d", MAX_DEPTH);
  end

  logic flush_w;
`ifdef FLIT_PIPE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  logic [DEPTH:0]            v, r;
  logic [DEPTH:0][WIDTH-1:0] d;

  assign v[0]      = in_valid;
  assign d[0]      = in_data;
  assign in_ready  = r[0];
  assign out_valid = v[DEPTH];
  assign out_data  = d[DEPTH];
  assign r[DEPTH]  = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    flit_skid_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clk       (clk),
      .rst       (reset),
      .flush_i   (flush_w),
      .up_valid_i(v[i]),
      .up_data_i (d[i]),
      .up_ready_o(r[i]),
      .dn_valid_o(v[i+1]),
      .dn_data_o (d[i+1]),
      .dn_ready_i(r[i+1])
    );
  end

  logic          in_fire, out_fire;
  logic [OW-1:0] occ_q, occ_d;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign occ      = occ_q;

  always_comb begin
    occ_d = occ_q;
    if (flush_w)                occ_d = '0;
    else if (in_fire && !out_fire) occ_d = occ_q + OW'(1);
    else if (out_fire && !in_fire) occ_d = occ_q - OW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end
endmodule

// File: tb/tb_flit_pipe_skid.sv
// Scoreboard bench for flit_pipe_skid at DEPTH 1, 2 and 3 in parallel.
module tb_flit_pipe_skid;
  import flit_pipe_pkg::*;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;
  localparam int NINST = 3;

  logic clk = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < NINST; g++) begin : gi
    localparam int D  = g + 1;
    localparam int OW = occ_width(D);
    localparam int T  = (2 * D < 3) ? 2 * D : 3;

    logic          rst, in_valid, in_ready, out_valid, out_ready, flush;
    logic [31:0]   in_data, out_data;
    logic [OW-1:0] occ;
    logic [31:0]   q[$];
    bit            pop_p;

    flit_pipe_skid #(.WIDTH(32), .DEPTH(D), .RESET_VAL(RV)) dut (
      .clk      (clk),
      .reset    (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .out_valid(out_valid),
      .out_data (out_data),
      .out_ready(out_ready),
`ifdef FLIT_PIPE_FLUSH_EN
      .flush    (flush),
`endif
      .occ      (occ)
    );

    // Monitor: occupancy versus reference queue, and output order.
    always begin
      @(negedge clk);
      #4;
      pop_p = 1'b0;
      if (!rst) begin
        chk($sformatf("d%0d_occ", D), 32'(occ), q.size());
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL d%0d_unexpected_out: got %h expected no output", D, out_data);
          end else begin
            chk($sformatf("d%0d_data", D), out_data, q[0]);
            pop_p = 1'b1;
          end
        end
      end
      @(posedge clk);
      if (pop_p && !rst) void'(q.pop_front());
    end

    // One cycle of stimulus; probes for combinational paths while inputs wiggle.
    task automatic cyc(input bit iv, input logic [31:0] id, input bit ordy, input bit fl,
                       output bit acc, output bit ov, output bit ir);
      bit a, o, fire;
      @(negedge clk);
      in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
      #1;
      a = in_ready; o = out_valid; ov = out_valid; ir = in_ready;
      in_valid = ~iv; in_data = ~id; out_ready = ~ordy;
      #1;
      chk($sformatf("d%0d_comb_in_ready", D), 32'(in_ready), 32'(a));
      chk($sformatf("d%0d_comb_out_valid", D), 32'(out_valid), 32'(o));
      in_valid = iv; in_data = id; out_ready = ordy;
      #1;
      fire = iv && in_ready && !fl && !rst;
      acc = fire;
      @(posedge clk);
      if (fire) q.push_back(id);
      if (fl) begin
        #1;
        q.delete();
      end
    endtask

    initial begin : drv
      bit acc, ov, ir;
      int n, first, cnt, bub;
      bit ovs[0:127];
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
      #3;
      chk($sformatf("d%0d_rst_out_valid", D), 32'(out_valid), 0);
      chk($sformatf("d%0d_rst_out_data", D), out_data, RV);
      chk($sformatf("d%0d_rst_occ", D), 32'(occ), 0);
      chk($sformatf("d%0d_rst_in_ready", D), 32'(in_ready), 1);
      @(negedge clk);
      rst = 1'b0;

      // Streaming 1..100 with downstream always ready.
      n = 0;
      for (int i = 0; i < D + 104; i++) begin
        cyc(i < 100, 32'(i + 1), 1'b1, 1'b0, acc, ov, ir);
        ovs[i] = ov;
        if (acc) n++;
      end
      first = -1; cnt = 0; bub = 0;
      for (int i = 0; i < D + 104; i++) begin
        if (ovs[i] && first < 0) first = i;
        if (ovs[i]) cnt++;
      end
      for (int i = 0; i < 100; i++) if (first >= 0 && !ovs[first + i]) bub++;
      chk($sformatf("d%0d_stream_acc", D), n, 100);
      chk($sformatf("d%0d_stream_latency", D), first, D);
      chk($sformatf("d%0d_stream_bubbles", D), bub, 0);
      chk($sformatf("d%0d_stream_count", D), cnt, 100);

      // Fill with downstream stalled, then drain.
      n = 0;
      for (int i = 0; i < 2 * D + 4; i++) begin
        cyc(1'b1, 32'(1000 + n), 1'b0, 1'b0, acc, ov, ir);
        if (acc) n++;
      end
      in_valid = 1'b0;
      chk($sformatf("d%0d_fill_acc", D), n, 2 * D);
      @(negedge clk);
      #1;
      chk($sformatf("d%0d_full_in_ready", D), 32'(in_ready), 0);
      chk($sformatf("d%0d_full_occ", D), 32'(occ), 2 * D);
      first = -1;
      for (int i = 0; i < 3 * D + 3; i++) begin
        cyc(1'b0, 32'h0, 1'b1, 1'b0, acc, ov, ir);
        if (ir && first < 0) first = i;
      end
      chk($sformatf("d%0d_refill_ready", D), first, D);

      // Random valid/ready at 50%.
      for (int i = 0; i < 3000; i++)
        cyc(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0, acc, ov, ir);
      for (int i = 0; i < 2 * D + 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, acc, ov, ir);

      // Alternating downstream ready with continuous input.
      for (int i = 0; i < 40; i++) cyc(1'b1, 32'(5000 + i), 1'(i % 2), 1'b0, acc, ov, ir);
      for (int i = 0; i < 2 * D + 4; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0, acc, ov, ir);

`ifdef FLIT_PIPE_FLUSH_EN
      n = 0;
      while (n < T) begin
        cyc(1'b1, 32'(7000 + n), 1'b0, 1'b0, acc, ov, ir);
        if (acc) n++;
      end
      cyc(1'b1, 32'hF00D_F00D, 1'b1, 1'b1, acc, ov, ir);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      #1;
      chk($sformatf("d%0d_flush_occ", D), 32'(occ), 0);
      chk($sformatf("d%0d_flush_out_valid", D), 32'(out_valid), 0);
`endif

      // Asynchronous reset with flits in flight.
      n = 0;
      while (n < T) begin
        cyc(1'b1, 32'(9000 + n), 1'b0, 1'b0, acc, ov, ir);
        if (acc) n++;
      end
      in_valid = 1'b0;
      @(negedge clk);
      #2;
      rst = 1'b1;
      q.delete();
      #1;
      chk($sformatf("d%0d_mid_rst_out_valid", D), 32'(out_valid), 0);
      chk($sformatf("d%0d_mid_rst_out_data", D), out_data, RV);
      chk($sformatf("d%0d_mid_rst_occ", D), 32'(occ), 0);
      chk($sformatf("d%0d_mid_rst_in_ready", D), 32'(in_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 2 * D + 2; i++) begin
        cyc(1'b0, 32'h0, 1'b1, 1'b0, acc, ov, ir);
        if (ov) cnt++;
      end
      chk($sformatf("d%0d_post_rst_outputs", D), cnt, 0);
      done_cnt++;
    end
  end

  initial begin
    fork
      wait (done_cnt == NINST);
      begin
        #1_000_000;
        failures++;
        $display("FAIL timeout: got done=%0d expected %0d", done_cnt, NINST);
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
